// File: rtl/sar_comp_search16_if.sv
// Handshake bundle between the SAR search block, its controller and the comparator.
// The search block drives the probe side; the environment answers through gt_in/gt_valid.
interface sar_comp_search16_if #(
    parameter int W = 16
);
    localparam int IW = $clog2(W);

    logic          start;
    logic          abort;
    logic [W-1:0]  probe;
    logic          probe_valid;
    logic          gt_in;
    logic          gt_valid;
    logic          busy;
    logic          done;
    logic [W-1:0]  value;
    logic [IW-1:0] bit_idx;

    modport master (
        input  start, abort, gt_in, gt_valid,
        output probe, probe_valid, busy, done, value, bit_idx
    );

    modport slave (
        output start, abort, gt_in, gt_valid,
        input  probe, probe_valid, busy, done, value, bit_idx
    );
endinterface

// File: rtl/sar_comp_search16.sv
// Successive-approximation search that recovers a hidden target from the 1-bit
// results of an external comparator (gt = probe > target), resolving MSB first.
module sar_comp_search16 #(
    parameter int W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    sar_comp_search16_if.master   bus
);
    localparam int IW = $clog2(W);
    localparam logic [IW-1:0] TOP_IDX = IW'(W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PROBE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  value_q, value_d;
    logic [IW-1:0] bit_idx_q, bit_idx_d;
    logic [W-1:0]  bit_mask_s;

    assign bit_mask_s = {{(W-1){1'b0}}, 1'b1} << bit_idx_q;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            value_q   <= {W{1'b0}};
            bit_idx_q <= TOP_IDX;
        end else begin
            state_q   <= state_d;
            value_q   <= value_d;
            bit_idx_q <= bit_idx_d;
        end
    end

    // Next-state logic; abort overrides both start and a same-cycle response
    always_comb begin
        state_d   = state_q;
        value_d   = value_q;
        bit_idx_d = bit_idx_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (bus.start) begin
                    state_d   = ST_PROBE;
                    value_d   = {W{1'b0}};
                    bit_idx_d = TOP_IDX;
                end else begin
                    state_d   = state_q;
                end
            end
            ST_PROBE: begin
                if (bus.gt_valid) begin
                    if (!bus.gt_in) begin
                        value_d = value_q | bit_mask_s;
                    end else begin
                        value_d = value_q;
                    end
                    if (bit_idx_q == {IW{1'b0}}) begin
                        state_d = ST_DONE;
                    end else begin
                        bit_idx_d = bit_idx_q - {{(IW-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = ST_PROBE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                value_d   = {W{1'b0}};
                bit_idx_d = TOP_IDX;
            end
        endcase
        if (bus.abort) begin
            state_d   = ST_IDLE;
            value_d   = {W{1'b0}};
            bit_idx_d = TOP_IDX;
        end else begin
            state_d   = state_d;
        end
    end

    assign bus.probe       = value_q | bit_mask_s;
    assign bus.probe_valid = (state_q == ST_PROBE);
    assign bus.busy        = (state_q == ST_PROBE);
    assign bus.done        = (state_q == ST_DONE);
    assign bus.value       = value_q;
    assign bus.bit_idx     = bit_idx_q;
endmodule

// File: tb/tb_sar_comp_search16.sv
// Randomized self-checking bench for sar_comp_search16 with a behavioural
// comparator responder and a prefix-of-target model of the expected probes.
module tb_sar_comp_search16;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    int   exp_bit;

    sar_comp_search16_if #(.W(16)) bus ();

    sar_comp_search16 #(.W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected probe while resolving bit b: target bits above b, then a 1 at b.
    function automatic logic [15:0] exp_probe(input logic [15:0] tgt, input int b);
        logic [31:0] hi;
        hi = ({16'd0, tgt} >> (b + 1)) << (b + 1);
        return hi[15:0] | (16'd1 << b);
    endfunction

    task automatic check_idle(input string tag);
        check({tag, ".busy"},        {31'd0, bus.busy},        32'd0);
        check({tag, ".done"},        {31'd0, bus.done},        32'd0);
        check({tag, ".probe_valid"}, {31'd0, bus.probe_valid}, 32'd0);
        check({tag, ".value"},       {16'd0, bus.value},       32'd0);
        check({tag, ".bit_idx"},     {28'd0, bus.bit_idx},     32'd15);
        check({tag, ".probe"},       {16'd0, bus.probe},       32'h8000);
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        exp_bit = 15;
        check("start.busy", {31'd0, bus.busy}, 32'd1);
        check("start.done", {31'd0, bus.done}, 32'd0);
    endtask

    // One probe: wait lat cycles with gt_valid low, then answer as the comparator.
    task automatic respond(input logic [15:0] tgt, input int lat, input logic st);
        logic [15:0] ep;
        ep = exp_probe(tgt, exp_bit);
        for (int w = 0; w < lat; w++) begin
            check("wait.probe",   {16'd0, bus.probe},   {16'd0, ep});
            check("wait.bit_idx", {28'd0, bus.bit_idx}, exp_bit);
            bus.gt_valid = 1'b0;
            tick();
        end
        check("probe",       {16'd0, bus.probe},       {16'd0, ep});
        check("bit_idx",     {28'd0, bus.bit_idx},     exp_bit);
        check("probe_valid", {31'd0, bus.probe_valid}, 32'd1);
        check("not_done",    {31'd0, bus.done},        32'd0);
        bus.gt_valid = 1'b1;
        bus.gt_in    = (bus.probe > tgt);
        bus.start    = st;
        tick();
        bus.gt_valid = 1'b0;
        bus.gt_in    = 1'b0;
        bus.start    = 1'b0;
        exp_bit--;
    endtask

    task automatic full_search(input logic [15:0] tgt, input int lat, input logic start_last);
        do_start();
        for (int k = 0; k < 16; k++) begin
            respond(tgt, lat, start_last && (k == 15));
        end
        check("end.done",  {31'd0, bus.done},        32'd1);
        check("end.busy",  {31'd0, bus.busy},        32'd0);
        check("end.pv",    {31'd0, bus.probe_valid}, 32'd0);
        check("end.value", {16'd0, bus.value},       {16'd0, tgt});
    endtask

    initial begin
        logic [15:0] tgt;
        logic [15:0] held_probe;
        int          lat;
        n_checks     = 0;
        n_errors     = 0;
        exp_bit      = 15;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.gt_in    = 1'b0;
        bus.gt_valid = 1'b0;
        tick();
        check_idle("reset");
        rst = 1'b0;
        tick();
        check_idle("post_reset");

        full_search(16'hA5C3, 0, 1'b0);
        full_search(16'h0000, 0, 1'b0);
        full_search(16'hFFFF, 0, 1'b0);
        full_search(16'h1234, 3, 1'b0);

        // gt_valid while in DONE must not disturb the frozen result
        bus.gt_valid = 1'b1;
        bus.gt_in    = 1'b0;
        tick();
        bus.gt_valid = 1'b0;
        check("done_gt.value", {16'd0, bus.value}, 32'h1234);
        check("done_gt.done",  {31'd0, bus.done},  32'd1);

        for (int r = 0; r < 8; r++) begin
            tgt = 16'($urandom_range(0, 65535));
            lat = $urandom_range(0, 2);
            full_search(tgt, lat, 1'b0);
        end

        // Start during PROBE ignored; abort beats a same-cycle response
        tgt = 16'h3C5A;
        do_start();
        for (int k = 0; k < 8; k++) respond(tgt, 0, 1'b0);
        held_probe = bus.probe;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("ign_start.bit_idx", {28'd0, bus.bit_idx}, 32'd7);
        check("ign_start.probe",   {16'd0, bus.probe},   {16'd0, held_probe});
        check("ign_start.busy",    {31'd0, bus.busy},    32'd1);
        respond(tgt, 0, 1'b0);
        respond(tgt, 0, 1'b0);
        check("pre_abort.bit_idx", {28'd0, bus.bit_idx}, 32'd5);
        bus.abort    = 1'b1;
        bus.gt_valid = 1'b1;
        bus.gt_in    = 1'b0;
        tick();
        bus.abort    = 1'b0;
        bus.gt_valid = 1'b0;
        check_idle("abort");
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check_idle("abort_idle");

        // Asynchronous reset between edges, then a clean recovery
        do_start();
        for (int k = 0; k < 6; k++) respond(16'h5A5A, 0, 1'b0);
        check("pre_rst.bit_idx", {28'd0, bus.bit_idx}, 32'd9);
        #2 rst = 1'b1;
        #1 check_idle("async_rst");
        #2 rst = 1'b0;
        tick();
        check_idle("after_rst");
        full_search(16'h7FFE, 0, 1'b0);

        // Start coinciding with final response is ignored; then restart from DONE
        full_search(16'h00FF, 0, 1'b1);
        tick();
        check("last_start.done",  {31'd0, bus.done},  32'd1);
        check("last_start.value", {16'd0, bus.value}, 32'h00FF);
        full_search(16'hFF00, 1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
